// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and output stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32
);
  logic                  fifo_empty;
  logic [DEPTH:0]        fifo_count;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // Reader side: consumes the FIFO read port and drives the output stream
  modport master (
    input  fifo_empty, fifo_count, fifo_valid, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  // Environment side: the FIFO plus the downstream consumer
  modport slave (
    output fifo_empty, fifo_count, fifo_valid, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a 1-cycle-latency FIFO into a bursted valid/ready stream
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_reader_if.master bus,
  output logic                busy,
  output logic                timeout_flush,
  output logic [15:0]         burst_count,
  output logic                err
);
  localparam int unsigned   CW         = DEPTH + 1;
  localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BURST_C    = CW'(BURST_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  rst_seen_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q;
  logic [15:0]           burst_count_q;
  logic                  err_q;

  logic rd_en, last_issue, flush, burst_done;
  logic pop, push, stray, room;

  assign pop   = bus.m_valid && bus.m_ready;
  assign push  = !rst && bus.fifo_valid && inflight_q;
  // A stray return right after reset release may belong to a read issued before reset
  assign stray = !rst && bus.fifo_valid && !inflight_q && !rst_seen_q;
  // Buffer slots left once in-flight data lands, counting a word leaving this cycle
  assign room  = ({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});

  // Next-state, read issue and timeout decision
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = '0;
    rd_en       = 1'b0;
    last_issue  = 1'b0;
    flush       = 1'b0;
    burst_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (bus.fifo_count >= BURST_C) begin
            state_d     = S_READ;
            remaining_d = BURST_C;
          end else if (!bus.fifo_empty) begin
            if (timer_q == TIMER_LAST) begin
              state_d     = S_READ;
              remaining_d = bus.fifo_count;
              flush       = 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        S_READ: begin
          if ((remaining_q != '0) && !bus.fifo_empty && room) begin
            rd_en       = 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CW'(1)) begin
              last_issue = 1'b1;
              state_d    = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((occ_q == 2'd0) && !inflight_q) begin
            state_d    = S_IDLE;
            burst_done = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state, read tracking, burst counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      timer_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rst_seen_q      <= 1'b1;
      burst_count_q   <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      timer_q         <= timer_d;
      inflight_q      <= rd_en;
      inflight_last_q <= last_issue;
      rst_seen_q      <= 1'b0;
      if (burst_done) burst_count_q <= burst_count_q + 16'd1;
      if (stray) err_q <= 1'b1;
    end
  end

  // Two-entry output buffer; the last flag travels with the word it tags
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q         <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= 2'b00;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.fifo_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = !rst && (occ_q != 2'd0);
  assign bus.m_data     = bus.m_valid ? buf_data_q[rd_ptr_q] : '0;
  assign bus.m_last     = bus.m_valid && buf_last_q[rd_ptr_q];
  assign busy           = !rst && (state_q != S_IDLE);
  assign timeout_flush  = flush;
  assign burst_count    = burst_count_q;
  assign err            = err_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int BL    = 4;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, timeout_flush, err;
  logic [15:0] burst_count;

  fifo_burst_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .busy          (busy),
    .timeout_flush (timeout_flush),
    .burst_count   (burst_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  // FIFO model with fixed 1-cycle read latency
  logic [7:0] mem [0:1023];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  logic       hide = 1'b0, force_valid = 1'b0, tb_flush = 1'b0;
  logic       fv_q = 1'b0;
  logic [7:0] fd_q = '0;

  assign bus.fifo_empty = (fifo_wr == fifo_rd) || hide;
  assign bus.fifo_count = 33'(fifo_wr - fifo_rd);
  assign bus.fifo_valid = fv_q || force_valid;
  assign bus.fifo_data  = fd_q;

  always @(posedge clk) begin
    fv_q <= 1'b0;
    if (tb_flush) begin
      fifo_rd <= fifo_wr;
    end else if (bus.fifo_rd_en && (fifo_wr != fifo_rd)) begin
      fd_q    <= mem[fifo_rd[9:0]];
      fifo_rd <= fifo_rd + 1;
      fv_q    <= 1'b1;
    end
  end

  // Output monitor: collects accepted words and protocol counters
  logic [8:0] rx [$];
  int         run_q [$];
  int         flush_cyc [$];
  int         cyc = 0, run = 0, n_rd = 0, n_rd_empty = 0, n_unstable = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (bus.fifo_rd_en) n_rd = n_rd + 1;
      if (bus.fifo_rd_en && bus.fifo_empty) n_rd_empty = n_rd_empty + 1;
      if (timeout_flush) flush_cyc.push_back(cyc);
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        n_unstable = n_unstable + 1;
      if (bus.m_valid && bus.m_ready) begin
        rx.push_back({bus.m_last, bus.m_data});
        run = run + 1;
        if (bus.m_last) begin
          run_q.push_back(run);
          run = 0;
        end
      end else begin
        run = 0;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end else begin
      prev_stall = 1'b0;
      run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  logic rand_ready = 1'b0, ready_level = 1'b0, rand_hide = 1'b0, toggle_hide = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    hide = toggle_hide ? ~hide : (rand_hide && ($urandom_range(0, 7) == 0));
  endtask

  // Reference: a batch loaded at once splits into full bursts plus one flushed remainder
  logic [8:0] exp_q [$];
  int         exp_bursts = 0, exp_flushes = 0;
  int         rx_ptr = 0, exp_ptr = 0;

  task automatic load(input int n, input bit random_data, input bit track);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = random_data ? 8'($urandom) : 8'(i);
      mem[fifo_wr[9:0]] = w;
      fifo_wr = fifo_wr + 1;
      if (track) exp_q.push_back({((i % BL) == BL - 1) || (i == n - 1), w});
    end
    if (track) begin
      exp_bursts  += (n + BL - 1) / BL;
      exp_flushes += ((n % BL) != 0) ? 1 : 0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((((rx.size() - rx_ptr) < (exp_q.size() - exp_ptr)) || busy) && (k < budget)) begin
      step();
      k++;
    end
    check({tag, "_done"}, 32'(k < budget), 32'd1);
    repeat (3) step();
    while (exp_ptr < exp_q.size()) begin
      check({tag, "_word"}, (rx_ptr < rx.size()) ? 32'(rx[rx_ptr]) : 32'hDEAD, 32'(exp_q[exp_ptr]));
      rx_ptr++;
      exp_ptr++;
    end
    check({tag, "_extra"}, 32'(rx.size() - rx_ptr), 32'd0);
  endtask

  int load_cyc, rd0, k;

  initial begin
    rst = 1'b1;
    bus.m_ready = 1'b0;
    repeat (3) step();
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_flush", timeout_flush, 0);
    check("rst_burst_count", burst_count, 0);
    check("rst_err", err, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    rst = 1'b0;

    // Two full bursts at full throughput
    ready_level = 1'b1;
    step();
    load(8, 1'b0, 1'b1);
    drain("t1", 300);
    check("t1_bursts", burst_count, 32'(exp_bursts));
    check("t1_run_a", 32'(run_q[run_q.size() - 2]), 4);
    check("t1_run_b", 32'(run_q[run_q.size() - 1]), 4);
    check("t1_no_flush", 32'(flush_cyc.size()), 0);

    // Partial burst flushed after the idle timeout
    load_cyc = cyc;
    load(3, 1'b0, 1'b1);
    drain("t2", 300);
    check("t2_flush_count", 32'(flush_cyc.size()), 1);
    check("t2_flush_delay", 32'(flush_cyc[0] - load_cyc), TO);
    check("t2_bursts", burst_count, 32'(exp_bursts));

    // Downstream stall: buffer fills, reads stop, head word held
    ready_level = 1'b0;
    step();
    rd0 = n_rd;
    load(8, 1'b0, 1'b1);
    repeat (30) step();
    check("t3_stall_reads", 32'(n_rd - rd0), 2);
    check("t3_stall_valid", bus.m_valid, 1);
    check("t3_stall_data", bus.m_data, 0);
    check("t3_stable", 32'(n_unstable), 0);
    ready_level = 1'b1;
    drain("t3", 300);
    check("t3_run_a", 32'(run_q[run_q.size() - 2]), 4);
    check("t3_run_b", 32'(run_q[run_q.size() - 1]), 4);
    check("t3_bursts", burst_count, 32'(exp_bursts));

    // Reset in the middle of a burst
    step();
    load(4, 1'b1, 1'b0);
    k = 0;
    while ((rx.size() <= rx_ptr) && (k < 50)) begin
      step();
      k++;
    end
    check("t4_first_word", 32'(k < 50), 1);
    rst = 1'b1;
    tb_flush = 1'b1;
    step();
    rst = 1'b0;
    tb_flush = 1'b0;
    check("t4_m_valid", bus.m_valid, 0);
    check("t4_rd_en", bus.fifo_rd_en, 0);
    check("t4_busy", busy, 0);
    check("t4_burst_count", burst_count, 0);
    rx_ptr = rx.size();
    exp_bursts = 0;

    // Stray read data sets the sticky error
    step();
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    check("t5_err_set", err, 1);
    check("t5_m_valid", bus.m_valid, 0);
    repeat (5) step();
    check("t5_err_sticky", err, 1);
    rst = 1'b1;
    step();
    check("t5_err_cleared", err, 0);
    rst = 1'b0;
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    step();
    check("t5_err_first_cycle", err, 0);
    rx_ptr = rx.size();
    exp_bursts = 0;

    // Empty flag toggling while reading
    toggle_hide = 1'b1;
    load(4, 1'b1, 1'b1);
    drain("t6", 300);
    toggle_hide = 1'b0;
    check("t6_rd_while_empty", 32'(n_rd_empty), 0);
    check("t6_bursts", burst_count, 32'(exp_bursts));

    // Randomized batches with random backpressure and empty glitches
    rand_ready = 1'b1;
    rand_hide = 1'b1;
    for (int b = 0; b < 6; b++) begin
      load(int'($urandom_range(1, 11)), 1'b1, 1'b1);
      drain("t7", 3000);
    end
    rand_ready = 1'b0;
    rand_hide = 1'b0;
    step();
    check("t7_bursts", burst_count, 32'(exp_bursts));
    check("t7_flushes", 32'(flush_cyc.size()), 32'(exp_flushes));
    check("t7_rd_while_empty", 32'(n_rd_empty), 0);
    check("t7_stable", 32'(n_unstable), 0);
    check("t7_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
